idct_tbuf_pingpong: RTL and testbench
=====================================

# idct_tbuf_pingpong

Parametrised ping-pong transpose buffer between the row-pass and column-pass IDCT engines. It holds two banks, each one MAXN×MAXN block. A writer fills one bank in row-major order while a reader drains the other in column-major (transposed) order. Both sides use valid/ready handshakes. Block size (full or half MAXN) is selectable per block, which generalises the fixed 8×8/4×4 two-mode RAM.

## Interface
- DW, 16, sample width in bits
- MAXN, 8, maximum block dimension; power of two, ≥4
- LGN, $clog2(MAXN), derived; not overridden
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- size_sel  in  1  1 = MAXN×MAXN block, 0 = (MAXN/2)×(MAXN/2); sampled only on the first accepted write of a block
- in_valid  in  1  write sample valid
- in_ready  out  1  buffer can accept a write; combinational, = !full[wr_bank]
- in_data  in  DW  row-major sample
- out_valid  out  1  out_data valid (registered)
- out_ready  in  1  downstream accepts
- out_data  out  DW  transposed sample (registered)
- out_last  out  1  marks final sample of a block, qualified by out_valid
- bank_full  out  2  per-bank full flags, for debug/status

## Operation
- Storage is 2×MAXN² words. Address is {bank, row[LGN-1:0], col[LGN-1:0]}. Storage is not reset; only control is reset.
- Writer: the write pointer is wr_bank plus wr_row/wr_col. A write is accepted on in_valid && in_ready.
  - On the first accepted write of a block, size_sel is latched into bsize[wr_bank], giving N = MAXN or MAXN/2.
  - wr_col increments; at N-1 it wraps to 0 and wr_row increments.
  - On the N²-th write: full[wr_bank] sets, wr_bank toggles, and the pointers clear.
- Reader FSM:
  - IDLE → DRAIN when full[rd_bank] is set.
  - In DRAIN, a read is issued when !out_valid || out_ready. Order is rd_row inner (0..N-1), rd_col outer, using bsize[rd_bank].
  - The read issued at (row N-1, col N-1) is the last read: it clears full[rd_bank], toggles rd_bank and returns to IDLE. The loaded output carries out_last = 1.
- Output register loads {data, last} on each read. out_valid clears on out_ready when no new read is issued that cycle.
- Sample k of an output block is element (row = k mod N, col = k div N).
- Simultaneous events:
  - The writer filling one bank and the reader freeing the other in the same cycle both take effect.
  - A bank freed at edge E is writable from cycle E+1.
- size_sel changes mid-block are ignored. Each bank drains with its own latched size.

## Timing
- Reset values: out_valid 0, out_data 0, out_last 0, bank_full 2'b00, in_ready 1, wr_bank/rd_bank 0, all pointers 0, reader IDLE.
- Latency: last write accepted at edge E → full set at E → first read at E+1 → out_valid high after E+1.
- Throughput is 1 sample/cycle each side. With out_ready held at 1, back-to-back blocks stream with no in_ready gaps.
- Both banks full and out_ready = 0 → in_ready = 0 until the current drain issues its last read.
- While out_valid && !out_ready, out_data and out_last hold stable.
- Reset asserted mid-operation returns all control to reset values immediately. Partial blocks are discarded.

## Structure
- Shared package idct_pkg holds:
  - DW and MAXN defaults
  - the reader state enum {RD_IDLE, RD_DRAIN}
  - a localparam for the full/half size encoding
- One sub-module, idct_dp_ram: a simple dual-port RAM of depth 2·MAXN², with one write port and one synchronous read port (registered data out), no reset. Top-level RTL holds the writer and reader control and the output register.

## Test plan
- 8×8, size_sel = 1, inputs 0..63, out_ready = 1 → outputs 0,8,16,…,56,1,9,…,63; out_last only on the 64th (value 63); first out_valid 1 cycle after the 64th write.
- 4×4, size_sel = 0, inputs 0..15 → outputs 0,4,8,12,1,5,…,15; out_last on 15; write pointer never exceeds row/col 3.
- Three consecutive 8×8 blocks with out_ready = 0 → in_ready drops after exactly 128 accepted writes; after raising out_ready, in_ready returns the cycle after block 1's last read and block 3 output is correct.
- Random out_ready backpressure over 4 mixed-size blocks → out_data/out_last stable while stalled; sequence matches the transpose model.
- size_sel toggled after the 10th write of an 8×8 block → still 64 outputs in 8×8 order; the next block uses the new size.
- rst_n pulsed mid-drain at sample 20 → out_valid 0, bank_full 00, in_ready 1 during reset; a following 4×4 block is transposed correctly.

Source files
------------

// File: rtl/idct_pkg.sv
// rtl/idct_pkg.sv - shared defaults and encodings for the IDCT transpose buffer
//
// Purpose: parameter defaults, reader state enum and block-size encoding
//          shared by idct_tbuf_pingpong and idct_dp_ram.
// Ports:   none (package).
package idct_pkg;

  localparam int IDCT_DW   = 16;
  localparam int IDCT_MAXN = 8;

  typedef enum logic [0:0] {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_t;

  // Per-block size encoding, as carried on size_sel and stored per bank.
  localparam logic SIZE_FULL = 1'b1;  // MAXN x MAXN
  localparam logic SIZE_HALF = 1'b0;  // (MAXN/2) x (MAXN/2)

endpackage

// File: rtl/idct_dp_ram.sv
// rtl/idct_dp_ram.sv - simple dual-port RAM, one write port, one registered read port
//
// Purpose: sample storage for both ping-pong banks. No reset on contents or
//          read data.
// Ports:   clk          - clock, rising edge
//          we/waddr/wdata - write port
//          re/raddr     - read request; rdata updates on the edge where re=1
//          rdata        - registered read data, holds while re=0
module idct_dp_ram
  import idct_pkg::*;
#(
  parameter int DW    = IDCT_DW,
  parameter int AW    = 7,
  parameter int DEPTH = 2 * IDCT_MAXN * IDCT_MAXN
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/idct_tbuf_pingpong.sv
// rtl/idct_tbuf_pingpong.sv - ping-pong transpose buffer between IDCT row and column passes
//
// Purpose: two banks of MAXN x MAXN samples. The writer fills one bank in
//          row-major order while the reader drains the other column-major.
//          Block size (MAXN or MAXN/2) is latched per bank on its first write.
// Ports:   clk, rst_n               - clock, async active-low reset
//          size_sel                 - 1 = full block, 0 = half block (first write only)
//          in_valid/in_ready/in_data   - row-major input handshake
//          out_valid/out_ready/out_data/out_last - transposed output handshake
//          bank_full                - per-bank full flags
module idct_tbuf_pingpong
  import idct_pkg::*;
#(
  parameter int DW   = IDCT_DW,
  parameter int MAXN = IDCT_MAXN,
  parameter int LGN  = $clog2(MAXN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          size_sel,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic [1:0]    bank_full
);

  localparam int AW = 2 * LGN + 1;
  localparam logic [LGN-1:0] IDX_FULL = LGN'(MAXN - 1);
  localparam logic [LGN-1:0] IDX_HALF = LGN'(MAXN / 2 - 1);

  logic [1:0]     full;
  logic [1:0]     full_nxt;
  logic [1:0]     bsize;
  logic           wr_bank;
  logic           rd_bank;
  logic [LGN-1:0] wr_row;
  logic [LGN-1:0] wr_col;
  logic [LGN-1:0] rd_row;
  logic [LGN-1:0] rd_col;
  rd_state_t      rd_state;
  logic [DW-1:0]  ram_q;

  logic           wr_en;
  logic           wr_first;
  logic           wr_size;
  logic           wr_last;
  logic [LGN-1:0] wr_max;
  logic           rd_issue;
  logic           rd_last;
  logic [LGN-1:0] rd_max;

  assign in_ready  = !full[wr_bank];
  assign bank_full = full;

  always_comb begin
    wr_en    = in_valid && in_ready;
    wr_first = (wr_row == '0) && (wr_col == '0);
    // The very first write of a block must already honour the new size_sel,
    // since bsize for this bank is only updated at the end of the cycle.
    wr_size  = wr_first ? size_sel : bsize[wr_bank];
    wr_max   = (wr_size == SIZE_FULL) ? IDX_FULL : IDX_HALF;
    wr_last  = (wr_row == wr_max) && (wr_col == wr_max);
  end

  always_comb begin
    rd_max   = (bsize[rd_bank] == SIZE_FULL) ? IDX_FULL : IDX_HALF;
    rd_last  = (rd_row == rd_max) && (rd_col == rd_max);
    // Reading starts in the same cycle IDLE observes a full bank, so the
    // first sample is presented one edge after the bank fills.
    rd_issue = ((rd_state == RD_DRAIN) || full[rd_bank]) && (!out_valid || out_ready);
  end

  // Set and clear always address different banks: the writer only targets a
  // non-full bank and the reader only a full one.
  always_comb begin
    full_nxt = full;
    if (wr_en && wr_last) begin
      full_nxt[wr_bank] = 1'b1;
    end
    if (rd_issue && rd_last) begin
      full_nxt[rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 2'b00;
      bsize    <= {SIZE_HALF, SIZE_HALF};
      wr_bank  <= 1'b0;
      wr_row   <= '0;
      wr_col   <= '0;
    end else begin
      full <= full_nxt;
      if (wr_en) begin
        if (wr_first) begin
          bsize[wr_bank] <= size_sel;
        end
        if (wr_last) begin
          wr_bank <= ~wr_bank;
          wr_row  <= '0;
          wr_col  <= '0;
        end else if (wr_col == wr_max) begin
          wr_col <= '0;
          wr_row <= wr_row + 1'b1;
        end else begin
          wr_col <= wr_col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
      rd_bank  <= 1'b0;
      rd_row   <= '0;
      rd_col   <= '0;
    end else begin
      if ((rd_state == RD_IDLE) && full[rd_bank]) begin
        rd_state <= RD_DRAIN;
      end
      if (rd_issue) begin
        if (rd_last) begin
          rd_bank  <= ~rd_bank;
          rd_row   <= '0;
          rd_col   <= '0;
          rd_state <= RD_IDLE;
        end else if (rd_row == rd_max) begin
          rd_row <= '0;
          rd_col <= rd_col + 1'b1;
        end else begin
          rd_row <= rd_row + 1'b1;
        end
      end
    end
  end

  // The RAM's registered read port is the output data register; valid and
  // last are loaded on the same edge as the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (rd_issue) begin
      out_valid <= 1'b1;
      out_last  <= rd_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  // RAM read data is not reset; present zero until a sample is valid.
  assign out_data = out_valid ? ram_q : '0;

  idct_dp_ram #(
    .DW   (DW),
    .AW   (AW),
    .DEPTH(2 * MAXN * MAXN)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr({wr_bank, wr_row, wr_col}),
    .wdata(in_data),
    .re   (rd_issue),
    .raddr({rd_bank, rd_row, rd_col}),
    .rdata(ram_q)
  );

endmodule

// File: tb/tb_idct_tbuf_pingpong.sv
// tb/tb_idct_tbuf_pingpong.sv - self-checking bench for idct_tbuf_pingpong
module tb_idct_tbuf_pingpong;

  localparam int DW   = 16;
  localparam int MAXN = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          size_sel = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [1:0]    bank_full;

  always #5 clk = ~clk;

  idct_tbuf_pingpong #(.DW(DW), .MAXN(MAXN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .size_sel (size_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .bank_full(bank_full)
  );

  int total = 0;
  int bad = 0;
  int n_out = 0;
  int acc_cnt = 0;
  int max_wr_idx = 0;
  logic [DW:0] exp_q[$];  // {last, data}, in expected output order

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  // Output monitor: checks every accepted sample against the transpose
  // model and checks that a stalled output holds still.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        total++;
        if (out_data !== prev_data || out_last !== prev_last || out_valid !== 1'b1) begin
          bad++;
          $display("FAIL stall_hold got valid=%0b data=%h last=%0b want valid=1 data=%h last=%0b",
                   out_valid, out_data, out_last, prev_data, prev_last);
        end
      end
      if (out_valid && out_ready) begin
        logic [DW:0] e;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out got data=%h last=%0b want no output", out_data, out_last);
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin
            bad++;
            $display("FAIL out_sample idx=%0d got data=%h last=%0b want data=%h last=%0b",
                     n_out, out_data, out_last, e[DW-1:0], e[DW]);
          end
        end
        n_out++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic write_block(input logic sz, input int toggle_after, input bit seq, input bit track_ptr);
    int n;
    int cyc;
    bit acc;
    logic [DW-1:0] blk [MAXN*MAXN];
    n = sz ? MAXN : MAXN / 2;
    for (int i = 0; i < n * n; i++) blk[i] = seq ? DW'(i) : DW'($urandom);
    // Output sample k is element (row = k mod n, col = k div n).
    for (int k = 0; k < n * n; k++) exp_q.push_back({(k == n * n - 1), blk[(k % n) * n + k / n]});
    for (int i = 0; i < n * n; i++) begin
      in_valid = 1'b1;
      in_data  = blk[i];
      size_sel = (toggle_after >= 0 && i >= toggle_after) ? ~sz : sz;
      cyc = 0;
      acc = 1'b0;
      while (!acc && cyc < 2000) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        cyc++;
      end
      if (!acc) begin
        total++;
        bad++;
        $display("FAIL write_timeout sample=%0d got in_ready=0 want 1", i);
        in_valid = 1'b0;
        return;
      end
      acc_cnt++;
      if (track_ptr) begin
        if (int'(dut.wr_row) > max_wr_idx) max_wr_idx = int'(dut.wr_row);
        if (int'(dut.wr_col) > max_wr_idx) max_wr_idx = int'(dut.wr_col);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    total++;
    if (exp_q.size() != 0 || out_valid) begin
      bad++;
      $display("FAIL drain_timeout got pending=%0d want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out_valid, out_last, out_data, bank_full, in_ready} !== {1'b0, 1'b0, {DW{1'b0}}, 2'b00, 1'b1}) begin
      bad++;
      $display("FAIL reset_state got valid=%0b last=%0b data=%h full=%b in_ready=%0b want 0 0 0 00 1",
               out_valid, out_last, out_data, bank_full, in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_8x8();
    out_ready = 1'b1;
    write_block(1'b1, -1, 1'b1, 1'b0);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || bank_full !== 2'b01) begin
      bad++;
      $display("FAIL latency_e got valid=%0b full=%b want valid=0 full=01", out_valid, bank_full);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_data !== '0) begin
      bad++;
      $display("FAIL latency_e1 got valid=%0b data=%h want valid=1 data=0", out_valid, out_data);
    end
    wait_drain();
    total++;
    if (bank_full !== 2'b00) begin
      bad++;
      $display("FAIL full_after_drain got %b want 00", bank_full);
    end
  endtask

  task automatic test_half_4x4();
    out_ready = 1'b1;
    max_wr_idx = 0;
    write_block(1'b0, -1, 1'b1, 1'b1);
    total++;
    if (max_wr_idx != MAXN / 2 - 1) begin
      bad++;
      $display("FAIL half_ptr_max got %0d want %0d", max_wr_idx, MAXN / 2 - 1);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int base;
    bit low_ok;
    bit found;
    out_ready = 1'b0;
    base = acc_cnt;
    write_block(1'b1, -1, 1'b0, 1'b0);
    write_block(1'b1, -1, 1'b0, 1'b0);
    total++;
    if (acc_cnt - base != 128) begin
      bad++;
      $display("FAIL stall_accepts got %0d want 128", acc_cnt - base);
    end
    low_ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || bank_full !== 2'b11) low_ok = 1'b0;
    end
    total++;
    if (!low_ok) begin
      bad++;
      $display("FAIL stall_in_ready got in_ready=%0b full=%b want 0 11", in_ready, bank_full);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clk);
      if (in_ready) begin
        found = 1'b1;
        total++;
        if (!(out_valid && out_last)) begin
          bad++;
          $display("FAIL ready_return got valid=%0b last=%0b want 1 1 when in_ready rises",
                   out_valid, out_last);
        end
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL ready_return_timeout got in_ready=0 want 1");
    end
    @(posedge clk);
    #1;
    write_block(1'b1, -1, 1'b0, 1'b0);
    wait_drain();
  endtask

  task automatic test_random_bp();
    bit wr_done;
    logic sizes [4];
    sizes[0] = 1'b1;
    sizes[1] = 1'b0;
    sizes[2] = 1'($urandom_range(0, 1));
    sizes[3] = 1'($urandom_range(0, 1));
    wr_done = 1'b0;
    fork
      begin
        for (int b = 0; b < 4; b++) write_block(sizes[b], -1, 1'b0, 1'b0);
        wr_done = 1'b1;
      end
      begin
        while (!wr_done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    for (int c = 0; c < 200; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_size_toggle();
    int base;
    out_ready = 1'b1;
    base = n_out;
    write_block(1'b1, 10, 1'b0, 1'b0);
    write_block(1'b0, -1, 1'b0, 1'b0);
    wait_drain();
    total++;
    if (n_out - base != 80) begin
      bad++;
      $display("FAIL toggle_count got %0d want 80", n_out - base);
    end
  endtask

  task automatic test_reset_mid_drain();
    int base;
    int cyc;
    out_ready = 1'b1;
    base = n_out;
    write_block(1'b1, -1, 1'b0, 1'b0);
    cyc = 0;
    while (n_out - base < 20 && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    total++;
    if (n_out - base != 20) begin
      bad++;
      $display("FAIL mid_drain_reach got %0d want 20", n_out - base);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, out_last, bank_full, in_ready} !== {1'b0, 1'b0, 2'b00, 1'b1}) begin
      bad++;
      $display("FAIL mid_reset got valid=%0b last=%0b full=%b in_ready=%0b want 0 0 00 1",
               out_valid, out_last, bank_full, in_ready);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_hold got valid=%0b in_ready=%0b want 0 1", out_valid, in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = n_out;
    write_block(1'b0, -1, 1'b1, 1'b0);
    wait_drain();
    total++;
    if (n_out - base != 16) begin
      bad++;
      $display("FAIL post_reset_count got %0d want 16", n_out - base);
    end
  endtask

  initial begin
    test_reset();
    test_full_8x8();
    test_half_4x4();
    test_back_to_back();
    test_random_bp();
    test_size_toggle();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
